// File: rtl/mult_issue.sv
`default_nettype none
// ============================================================================
// Module      : mult_issue
// Description : Issue stage for a sequential 8x8 multiplier.
//               - Accepts an unsigned operand pair over a valid/ready handshake.
//               - Registers the pair onto oper_a/oper_b.
//               - Sequences mult_control with one start cycle, then four
//                 count steps (00..11).
//               - Checks done in the following WAIT cycle.
//               - Presents the 16-bit product over a valid/ready handshake.
//               If done is missing in WAIT, the operation is dropped and err
//               pulses for one cycle.
// Config      : MULT_ISSUE_FIFO_EN - when defined, operands are buffered in a
//               2-entry FIFO. An empty FIFO is bypassed, so an idle engine
//               starts one cycle after acceptance in either build.
// Ports       : clk, reset_a (async, active-high)
//               in_valid/in_ready, dataa/datab  - operand handshake
//               oper_a/oper_b                   - registered operands
//               start/count/done/product        - mult_control + datapath
//               out_valid/out_ready/out_result  - result handshake
//               busy, err                       - status
// Revision    : 1.0 - initial release
// ============================================================================
module mult_issue (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic [7:0]  oper_a,
  output logic [7:0]  oper_b,
  output logic        start,
  output logic [1:0]  count,
  input  logic        done,
  input  logic [15:0] product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0] state;
  logic [2:0] state_next;
  logic [1:0] run_cnt;

  // Operand offered to the engine this cycle, and whether it is consumed.
  logic       avail;
  logic [7:0] avail_a;
  logic [7:0] avail_b;
  logic       take;

  // The engine only picks up new work from IDLE, or from OUT once the
  // current result is actually handed off.
  assign take = avail & ((state == S_IDLE) | ((state == S_OUT) & out_ready));

`ifdef MULT_ISSUE_FIFO_EN
  logic [7:0] fifo_a [2];
  logic [7:0] fifo_b [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] fill;
  logic       push;
  logic       wr_en;
  logic       rd_en;
  logic       empty;
  logic       full;

  assign empty    = (fill == 2'd0);
  assign full     = (fill == 2'd2);
  // A full FIFO refuses the push even if a pop happens in the same cycle.
  assign in_ready = ~reset_a & ~full;
  assign push     = in_valid & in_ready;
  // Bypass: an incoming pair on an empty FIFO is usable immediately.
  assign avail    = ~empty | push;
  assign avail_a  = empty ? dataa : fifo_a[rd_ptr];
  assign avail_b  = empty ? datab : fifo_b[rd_ptr];
  assign rd_en    = take & ~empty;
  // A bypassed pair is consumed directly and never stored.
  assign wr_en    = push & ~(take & empty);

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      fill   <= 2'd0;
    end else begin
      if (wr_en) wr_ptr <= ~wr_ptr;
      if (rd_en) rd_ptr <= ~rd_ptr;
      case ({wr_en, rd_en})
        2'b10:   fill <= fill + 2'd1;
        2'b01:   fill <= fill - 2'd1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_a[wr_ptr] <= dataa;
      fifo_b[wr_ptr] <= datab;
    end
  end
`else
  // Without buffering the pair is taken straight from the inputs, so
  // ready is only offered when the engine can start on it at once.
  assign in_ready = ~reset_a & ((state == S_IDLE) | ((state == S_OUT) & out_ready));
  assign avail    = in_valid & in_ready;
  assign avail_a  = dataa;
  assign avail_b  = datab;
`endif

  // State register
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (avail) state_next = S_START;
      S_START: state_next = S_RUN;
      S_RUN:   if (run_cnt == 2'd3) state_next = S_WAIT;
      S_WAIT:  state_next = done ? S_OUT : S_IDLE;
      S_OUT:   if (out_ready) state_next = avail ? S_START : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    start     = (state == S_START);
    count     = (state == S_RUN) ? run_cnt : 2'd0;
    out_valid = (state == S_OUT);
    busy      = (state != S_IDLE);
  end

  // Datapath registers. run_cnt wraps 11 -> 00 as RUN exits, so it is
  // already zero for the next operation.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      run_cnt    <= 2'd0;
      oper_a     <= 8'd0;
      oper_b     <= 8'd0;
      out_result <= 16'd0;
      err        <= 1'b0;
    end else begin
      run_cnt <= (state == S_RUN) ? run_cnt + 2'd1 : 2'd0;
      if (take) begin
        oper_a <= avail_a;
        oper_b <= avail_b;
      end
      if ((state == S_WAIT) && done) out_result <= product;
      err <= (state == S_WAIT) & ~done;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_issue
// Description : Directed self-checking bench for mult_issue.
//               A small model of mult_control returns done in the cycle after
//               count=11, and the product of the registered operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_issue;

  logic        clk = 1'b0;
  logic        reset_a;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [7:0]  oper_a;
  logic [7:0]  oper_b;
  logic        start;
  logic [1:0]  count;
  logic        done;
  logic [15:0] product;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        busy;
  logic        err;

  logic done_en;
  logic saw3;
  int   total = 0;
  int   bad   = 0;

  mult_issue dut (
    .clk(clk), .reset_a(reset_a), .in_valid(in_valid), .in_ready(in_ready),
    .dataa(dataa), .datab(datab), .oper_a(oper_a), .oper_b(oper_b),
    .start(start), .count(count), .done(done), .product(product),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Controller model: done in the cycle following count=11.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) saw3 <= 1'b0;
    else         saw3 <= (count == 2'd3);
  end
  assign done    = done_en & saw3;
  assign product = 16'(oper_a) * 16'(oper_b);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_a = 1'b1; in_valid = 1'b0; dataa = 8'd0; datab = 8'd0;
    out_ready = 1'b1; done_en = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (start !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL rst_start_count got=%b/%0d exp=0/0", start, count); end
    total++; if (out_valid !== 1'b0 || out_result !== 16'd0) begin bad++; $display("FAIL rst_out got=%b/%h exp=0/0000", out_valid, out_result); end
    total++; if (oper_a !== 8'd0 || oper_b !== 8'd0) begin bad++; $display("FAIL rst_oper got=%h/%h exp=00/00", oper_a, oper_b); end
    total++; if (busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_busy_err got=%b/%b exp=0/0", busy, err); end
    tick; tick;
    reset_a = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  // 13 * 11 = 143 with the full latency profile.
  task automatic test_basic;
    in_valid = 1'b1; dataa = 8'd13; datab = 8'd11; out_ready = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_accept got=%b exp=1", in_ready); end
    tick; in_valid = 1'b0;
    total++; if (start !== 1'b1 || count !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL basic_t1 got start=%b count=%0d busy=%b exp 1/0/1", start, count, busy); end
    total++; if (oper_a !== 8'd13 || oper_b !== 8'd11) begin bad++; $display("FAIL basic_oper got=%0d/%0d exp=13/11", oper_a, oper_b); end
    for (int k = 0; k < 4; k++) begin
      tick;
      total++; if (start !== 1'b0 || count !== 2'(k)) begin bad++; $display("FAIL basic_run got start=%b count=%0d exp 0/%0d", start, count, k); end
    end
    tick;
    total++; if (out_valid !== 1'b0 || busy !== 1'b1 || count !== 2'd0) begin bad++; $display("FAIL basic_wait got ov=%b busy=%b count=%0d exp 0/1/0", out_valid, busy, count); end
    tick;
    total++; if (out_valid !== 1'b1 || out_result !== 16'd143) begin bad++; $display("FAIL basic_out got ov=%b res=%0d exp 1/143", out_valid, out_result); end
    tick;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_idle got ov=%b busy=%b exp 0/0", out_valid, busy); end
  endtask

  // 255 * 255 = 0xFE01, operands held from START through WAIT.
  task automatic test_max;
    in_valid = 1'b1; dataa = 8'hFF; datab = 8'hFF; out_ready = 1'b1;
    tick; in_valid = 1'b0; dataa = 8'h00; datab = 8'h00;
    for (int k = 0; k < 6; k++) begin
      total++; if (oper_a !== 8'hFF || oper_b !== 8'hFF) begin bad++; $display("FAIL max_oper_stable cyc=%0d got=%h/%h exp=ff/ff", k, oper_a, oper_b); end
      tick;
    end
    total++; if (out_valid !== 1'b1 || out_result !== 16'hFE01) begin bad++; $display("FAIL max_result got ov=%b res=%h exp 1/fe01", out_valid, out_result); end
    tick;
  endtask

  // Missing done in WAIT -> one-cycle err, back to IDLE, no result.
  task automatic test_err;
    done_en = 1'b0;
    in_valid = 1'b1; dataa = 8'd9; datab = 8'd9; out_ready = 1'b1;
    tick; in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick;
    total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL err_wait got err=%b busy=%b exp 0/1", err, busy); end
    tick;
    total++; if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL err_pulse got err=%b busy=%b ov=%b exp 1/0/0", err, busy, out_valid); end
    tick;
    total++; if (err !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL err_clear got err=%b ov=%b exp 0/0", err, out_valid); end
    done_en = 1'b1;
  endtask

  // Result held under back-pressure; next start the cycle after release.
  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid = 1'b1; dataa = 8'd5; datab = 8'd6;
    tick; in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick;
    total++; if (out_valid !== 1'b1 || out_result !== 16'd30) begin bad++; $display("FAIL bp_first got ov=%b res=%0d exp 1/30", out_valid, out_result); end
    for (int k = 0; k < 5; k++) begin
      tick;
      total++; if (out_valid !== 1'b1 || out_result !== 16'd30 || start !== 1'b0) begin bad++; $display("FAIL bp_hold cyc=%0d got ov=%b res=%0d start=%b exp 1/30/0", k, out_valid, out_result, start); end
    end
    out_ready = 1'b1; in_valid = 1'b1; dataa = 8'd2; datab = 8'd3;
    tick; in_valid = 1'b0;
    total++; if (start !== 1'b1 || out_valid !== 1'b0 || oper_a !== 8'd2) begin bad++; $display("FAIL bp_restart got start=%b ov=%b oper_a=%0d exp 1/0/2", start, out_valid, oper_a); end
    for (int k = 0; k < 6; k++) tick;
    total++; if (out_valid !== 1'b1 || out_result !== 16'd6) begin bad++; $display("FAIL bp_second got ov=%b res=%0d exp 1/6", out_valid, out_result); end
    tick;
  endtask

  // Reset during RUN at count=10 clears everything at once; nothing follows.
  task automatic test_reset_mid;
    out_ready = 1'b1;
    in_valid = 1'b1; dataa = 8'd4; datab = 8'd4;
    tick; in_valid = 1'b0;
    tick; tick; tick;
    total++; if (count !== 2'd2) begin bad++; $display("FAIL mid_count got=%0d exp=2", count); end
    reset_a = 1'b1;
    #1;
    total++; if (start !== 1'b0 || count !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_reset got start=%b count=%0d busy=%b ov=%b rdy=%b exp 0/0/0/0/0", start, count, busy, out_valid, in_ready); end
    tick;
    reset_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick;
      total++; if (err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_after cyc=%0d got err=%b ov=%b busy=%b exp 0/0/0", k, err, out_valid, busy); end
    end
  endtask

`ifdef MULT_ISSUE_FIFO_EN
  // Three pairs pushed while busy: the third stalls, results stay in order.
  task automatic test_fifo;
    logic [7:0]  pa [3];
    logic [7:0]  pb [3];
    logic [15:0] ex [4];
    int pi;
    int ri;
    logic acc;
    pa[0] = 8'd3; pb[0] = 8'd4; pa[1] = 8'd5; pb[1] = 8'd6; pa[2] = 8'd7; pb[2] = 8'd8;
    ex[0] = 16'd2; ex[1] = 16'd12; ex[2] = 16'd30; ex[3] = 16'd56;
    pi = 0; ri = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; dataa = 8'd1; datab = 8'd2;
    tick;
    for (int c = 0; c < 80 && ri < 4; c++) begin
      if (pi < 3) begin in_valid = 1'b1; dataa = pa[pi]; datab = pb[pi]; end
      else in_valid = 1'b0;
      if (c == 2) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fifo_stall got=%b exp=0", in_ready); end
      end
      acc = in_valid & in_ready;
      tick;
      if (acc) pi++;
      if (out_valid === 1'b1) begin
        total++; if (out_result !== ex[ri]) begin bad++; $display("FAIL fifo_order idx=%0d got=%0d exp=%0d", ri, out_result, ex[ri]); end
        ri++;
      end
    end
    in_valid = 1'b0;
    total++; if (ri != 4) begin bad++; $display("FAIL fifo_timeout got=%0d results exp=4", ri); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_basic;
    test_max;
    test_err;
    test_backpressure;
    test_reset_mid;
`ifdef MULT_ISSUE_FIFO_EN
    test_fifo;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_issue.md
MULT_ISSUE -- requirements
Module: mult_issue

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset_a, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-004 SHALL have port in_ready, output, 1 bit: operand pair accepted when in_valid && in_ready.
REQ-005 SHALL have ports dataa and datab, input, 8 bits each: unsigned operands.
REQ-006 SHALL have ports oper_a and oper_b, output, 8 bits each: registered operands driven to the multiplier datapath.
REQ-007 SHALL have port start, output, 1 bit: start to mult_control.
REQ-008 SHALL have port count, output, 2 bits: step count to mult_control.
REQ-009 SHALL have port done, input, 1 bit: done from mult_control.
REQ-010 SHALL have port product, input, 16 bits: datapath product, valid while done=1.
REQ-011 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit) and out_result (output, 16 bits): result handshake.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse on a protocol fault.

Function
REQ-014 SHALL implement the states IDLE, START, RUN, WAIT, OUT.
REQ-015 IDLE: on an operand available, SHALL load oper_a/oper_b from it and go to START.
REQ-016 START: SHALL drive start=1 and count=00 for exactly one cycle, then go to RUN.
REQ-017 RUN: SHALL drive start=0 with count=00,01,10,11 on four consecutive cycles, then go to WAIT.
REQ-018 start SHALL be 0 in every state except START.
REQ-019 WAIT: if done=1, SHALL capture product into out_result and go to OUT.
REQ-020 WAIT: if done=0, SHALL pulse err for one cycle, drop the operation and go to IDLE.
REQ-021 OUT: SHALL hold out_valid=1 and out_result stable until out_valid && out_ready.
REQ-022 On leaving OUT, SHALL go to START if an operand is available, else to IDLE.
REQ-023 Latency from the accept cycle T SHALL be: start=1 at T+1, count=00..11 over T+2..T+5, done sampled at T+6, out_valid=1 at T+7.
REQ-024 oper_a/oper_b SHALL stay constant from START through WAIT.
REQ-025 count SHALL be 00 in every state except RUN.
REQ-026 out_result SHALL be product[15:0] with no truncation or sign handling.
REQ-027 Back-pressure: while out_valid=1 and out_ready=0, SHALL NOT start a new operation.

Reset
REQ-028 On reset_a=1, SHALL go to IDLE immediately, independent of clk.
REQ-029 Reset values SHALL be: start=0, count=00, out_valid=0, out_result=0, oper_a=0, oper_b=0, busy=0, err=0, FIFO empty.
REQ-030 in_ready SHALL be 0 while reset_a=1.
REQ-031 Reset mid-operation SHALL discard the in-flight operation and all buffered operands; no out_valid or err SHALL follow.

Configuration
REQ-032 Macro MULT_ISSUE_FIFO_EN SHALL control operand buffering.
REQ-033 With MULT_ISSUE_FIFO_EN defined: SHALL buffer operands in a 2-entry FIFO; in_ready = FIFO not full; accept while busy; an operand is "available" when the FIFO is non-empty; FIFO order SHALL be preserved.
REQ-034 With MULT_ISSUE_FIFO_EN defined: a push and a pop in the same cycle on a full FIFO SHALL be rejected (in_ready=0); on a non-full FIFO both SHALL complete.
REQ-035 Without MULT_ISSUE_FIFO_EN: SHALL have no FIFO; in_ready=1 only in IDLE, or in OUT when out_ready=1; an operand is "available" when in_valid && in_ready.

Verification
REQ-036 Reset then accept dataa=8'd13, datab=8'd11 with a model controller returning product=16'd143 -> start pulse at T+1, count 0,1,2,3 over T+2..T+5, out_valid at T+7 with out_result=143.
REQ-037 dataa=8'hFF, datab=8'hFF -> out_result=16'hFE01, with oper_a/oper_b stable through WAIT.
REQ-038 done held 0 in WAIT -> err pulse of one cycle, return to IDLE, no out_valid.
REQ-039 out_ready held 0 for 5 cycles -> out_result stable, no new start; out_ready=1 -> next start issued the following cycle.
REQ-040 With FIFO enabled, push 3 pairs back-to-back during busy -> third pair stalled (in_ready=0); results emerge in order 1, 2, 3.
REQ-041 Assert reset_a during RUN at count=10 -> start=0, count=00, busy=0, out_valid=0 immediately; no err pulse.
